// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer to writeback, status register {N,V,C,Z}, branch eval, V counter.
// Latency 1 cycle in to OUT_VALID; IN_READY is registered and drops only when both entries are full.
module alu_result_stage #(
    parameter int DW     = 8,
    parameter int DEST_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DW-1:0]     Y,
    input  logic              N,
    input  logic              V,
    input  logic              C,
    input  logic              Z,
    input  logic [DEST_W-1:0] DEST,
    input  logic              FLAG_WE,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DW-1:0]     OUT_Y,
    output logic [DEST_W-1:0] OUT_DEST,
    output logic [3:0]        SR,
    input  logic [2:0]        COND,
    output logic              TAKEN,
    input  logic              CLR_CNT,
    output logic [CNT_W-1:0]  VCOUNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              in_rdy_q;
    logic [DW-1:0]     main_y, skid_y;
    logic [DEST_W-1:0] main_dest, skid_dest;
    logic [3:0]        sr_q;
    logic [CNT_W-1:0]  vcnt_q;

    logic in_xfer, out_xfer;
    logic load_main_in, load_main_skid, load_skid;

    assign in_xfer  = IN_VALID & in_rdy_q;
    assign out_xfer = (state != EMPTY) & OUT_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= EMPTY;
            in_rdy_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_rdy_q <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_y    <= '0;
            main_dest <= '0;
            skid_y    <= '0;
            skid_dest <= '0;
        end else begin
            if (load_main_in) begin
                main_y    <= Y;
                main_dest <= DEST;
            end else if (load_main_skid) begin
                main_y    <= skid_y;
                main_dest <= skid_dest;
            end
            if (load_skid) begin
                skid_y    <= Y;
                skid_dest <= DEST;
            end
        end
    end

    // Flags commit at acceptance so branches see them before the result drains.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q <= 4'b0000;
        end else if (in_xfer && FLAG_WE) begin
            sr_q <= {N, V, C, Z};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR_CNT) begin
            vcnt_q <= '0;
        end else if (in_xfer && V && (vcnt_q != {CNT_W{1'b1}})) begin
            vcnt_q <= vcnt_q + 1'b1;
        end
    end

    always_comb begin
        TAKEN = 1'b1;
        case (COND)
            3'b000: TAKEN = 1'b1;
            3'b001: TAKEN = sr_q[0];
            3'b010: TAKEN = ~sr_q[0];
            3'b011: TAKEN = sr_q[3];
            3'b100: TAKEN = ~sr_q[3];
            3'b101: TAKEN = sr_q[2];
            3'b110: TAKEN = sr_q[1];
            3'b111: TAKEN = sr_q[3] ^ sr_q[2];
            default: TAKEN = 1'b1;
        endcase
    end

    assign IN_READY  = in_rdy_q;
    assign OUT_VALID = (state != EMPTY);
    assign OUT_Y     = main_y;
    assign OUT_DEST  = main_dest;
    assign SR        = sr_q;
    assign VCOUNT    = vcnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: handshake ordering, SR/TAKEN, counter saturation, reset.
module tb_alu_result_stage;

    logic       CLK = 1'b0;
    logic       RST, IN_VALID, IN_READY, N, V, C, Z, FLAG_WE;
    logic       OUT_VALID, OUT_READY, TAKEN, CLR_CNT;
    logic [7:0] Y, OUT_Y, VCOUNT;
    logic [2:0] DEST, OUT_DEST, COND;
    logic [3:0] SR;

    int checks   = 0;
    int failures = 0;

    alu_result_stage #(.DW(8), .DEST_W(3), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Y(Y), .N(N), .V(V), .C(C), .Z(Z), .DEST(DEST), .FLAG_WE(FLAG_WE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Y(OUT_Y), .OUT_DEST(OUT_DEST),
        .SR(SR), .COND(COND), .TAKEN(TAKEN),
        .CLR_CNT(CLR_CNT), .VCOUNT(VCOUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] y, input logic [3:0] nvcz, input logic [2:0] d, input logic fwe);
        IN_VALID = 1'b1;
        Y        = y;
        {N, V, C, Z} = nvcz;
        DEST     = d;
        FLAG_WE  = fwe;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; Y = '0; {N, V, C, Z} = 4'b0; DEST = '0;
        FLAG_WE = 1'b0; OUT_READY = 1'b0; COND = 3'b000; CLR_CNT = 1'b0;
        step(); step();
        RST = 1'b0;
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_in_ready", IN_READY, 1);
        check("rst_sr", SR, 0);
        check("rst_vcount", VCOUNT, 0);
        check("rst_out_y", OUT_Y, 0);
        check("rst_out_dest", OUT_DEST, 0);

        // Single pass
        OUT_READY = 1'b1;
        send(8'h80, 4'b1100, 3'd3, 1'b1);
        step();
        IN_VALID = 1'b0;
        check("pass_out_valid", OUT_VALID, 1);
        check("pass_out_y", OUT_Y, 8'h80);
        check("pass_out_dest", OUT_DEST, 3);
        check("pass_sr", SR, 4'b1100);
        check("pass_vcount", VCOUNT, 1);
        COND = 3'b111; #1;
        check("pass_taken_lt", TAKEN, 0);
        COND = 3'b011; #1;
        check("pass_taken_mi", TAKEN, 1);
        COND = 3'b101; #1;
        check("pass_taken_vs", TAKEN, 1);
        COND = 3'b110; #1;
        check("pass_taken_cs", TAKEN, 0);
        step();
        check("pass_drained", OUT_VALID, 0);

        // Backpressure
        OUT_READY = 1'b0;
        send(8'h11, 4'b0000, 3'd1, 1'b0);
        step();
        check("bp_rdy_after1", IN_READY, 1);
        send(8'h22, 4'b0000, 3'd2, 1'b0);
        step();
        check("bp_rdy_after2", IN_READY, 0);
        check("bp_hold_y1", OUT_Y, 8'h11);
        send(8'h33, 4'b0000, 3'd3, 1'b0);
        step();
        check("bp_rdy_stall", IN_READY, 0);
        check("bp_hold_y2", OUT_Y, 8'h11);
        check("bp_hold_dest", OUT_DEST, 1);
        OUT_READY = 1'b1;
        step();
        check("bp_out2_y", OUT_Y, 8'h22);
        check("bp_out2_dest", OUT_DEST, 2);
        check("bp_rdy_reopen", IN_READY, 1);
        step();
        IN_VALID = 1'b0;
        check("bp_out3_y", OUT_Y, 8'h33);
        check("bp_out3_valid", OUT_VALID, 1);
        step();
        check("bp_empty", OUT_VALID, 0);
        check("bp_vcount", VCOUNT, 1);

        // FLAG_WE gating
        send(8'h00, 4'b0001, 3'd4, 1'b1);
        step();
        send(8'h05, 4'b1110, 3'd5, 1'b0);
        step();
        IN_VALID = 1'b0;
        check("fwe_sr", SR, 4'b0001);
        check("fwe_out_y", OUT_Y, 8'h05);
        COND = 3'b001; #1;
        check("fwe_taken_eq", TAKEN, 1);
        COND = 3'b010; #1;
        check("fwe_taken_ne", TAKEN, 0);
        COND = 3'b000; #1;
        check("fwe_taken_al", TAKEN, 1);
        check("fwe_vcount", VCOUNT, 2);
        step();

        // Counter saturation and clear priority
        CLR_CNT = 1'b1;
        step();
        CLR_CNT = 1'b0;
        check("cnt_cleared", VCOUNT, 0);
        for (int i = 0; i < 255; i++) begin
            send(i[7:0], 4'b0100, 3'd0, 1'b0);
            step();
        end
        check("cnt_255", VCOUNT, 255);
        for (int i = 0; i < 5; i++) begin
            send(8'hF0, 4'b0100, 3'd0, 1'b0);
            step();
        end
        check("cnt_saturate", VCOUNT, 255);
        check("cnt_sr_untouched", SR, 4'b0001);
        CLR_CNT = 1'b1;
        send(8'hF1, 4'b0100, 3'd0, 1'b0);
        step();
        CLR_CNT = 1'b0;
        IN_VALID = 1'b0;
        check("cnt_clr_priority", VCOUNT, 0);
        step();
        check("cnt_stays_zero", VCOUNT, 0);

        // Full throughput
        for (int i = 0; i < 10; i++) begin
            send(i[7:0], 4'b0000, i[2:0], 1'b0);
            step();
            check("thr_in_ready", IN_READY, 1);
            check("thr_out_valid", OUT_VALID, 1);
            check("thr_out_y", OUT_Y, i);
        end
        IN_VALID = 1'b0;
        step();
        check("thr_empty", OUT_VALID, 0);

        // Reset mid-operation from TWO with SR=1010, VCOUNT=7
        for (int i = 0; i < 7; i++) begin
            send(8'h40 + i[7:0], 4'b0100, 3'd0, 1'b0);
            step();
        end
        OUT_READY = 1'b0;
        send(8'hAA, 4'b1010, 3'd6, 1'b1);
        step();
        send(8'hBB, 4'b0000, 3'd7, 1'b0);
        check("pre_rst_in_ready", IN_READY, 0);
        check("pre_rst_sr", SR, 4'b1010);
        check("pre_rst_vcount", VCOUNT, 7);
        RST = 1'b1;
        OUT_READY = 1'b1;
        step();
        RST = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check("mrst_out_valid", OUT_VALID, 0);
        check("mrst_in_ready", IN_READY, 1);
        check("mrst_sr", SR, 0);
        check("mrst_vcount", VCOUNT, 0);
        send(8'h5A, 4'b0000, 3'd2, 1'b0);
        step();
        IN_VALID = 1'b0;
        check("post_rst_y", OUT_Y, 8'h5A);
        check("post_rst_valid", OUT_VALID, 1);
        OUT_READY = 1'b1;
        step();
        check("post_rst_alone", OUT_VALID, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
